// File: rtl/life_engine.sv
// Cellular automaton core: W x H board in two ping-pong banks, one cell per
// cycle during STEP/FILL, with single-cycle TOGGLE edits and status outputs.
module life_engine #(
  parameter int          LOG_W        = 6,
  parameter int          LOG_H        = 5,
  parameter bit          WRAP         = 1'b1,
  parameter logic [8:0]  BIRTH_MASK   = 9'b000001000,
  parameter logic [8:0]  SURVIVE_MASK = 9'b000001100,
  parameter logic [15:0] SEED         = 16'h0001
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_op,
  input  logic [LOG_W-1:0]       cmd_x,
  input  logic [LOG_H-1:0]       cmd_y,
  input  logic [LOG_W-1:0]       rd_x,
  input  logic [LOG_H-1:0]       rd_y,
  output logic                   rd_cell,
  output logic                   busy,
  output logic                   done,
  output logic [15:0]            generation,
  output logic [LOG_W+LOG_H:0]   population,
  output logic                   stable,
  output logic [1:0]             dbg_state
);
  localparam int W     = 1 << LOG_W;
  localparam int H     = 1 << LOG_H;
  localparam int LOG_N = LOG_W + LOG_H;
  localparam int N     = 1 << LOG_N;
  localparam int PW    = LOG_N + 1;

  localparam logic [1:0] OP_STEP   = 2'd0;
  localparam logic [1:0] OP_RAND   = 2'd1;
  localparam logic [1:0] OP_TOGGLE = 2'd3;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_STEP = 2'd1, S_FILL = 2'd2} state_t;

  state_t            r_state, w_next;
  logic [N-1:0]      r_bank_a, r_bank_b;
  logic              r_front;
  logic [LOG_N-1:0]  r_idx;
  logic [15:0]       r_lfsr;
  logic              r_fill_rand;
  logic [PW-1:0]     r_acc;
  logic              r_diff;
  logic              r_done;
  logic [15:0]       r_gen;
  logic [PW-1:0]     r_pop;
  logic              r_stable;

  logic [N-1:0]      w_front_bank;
  logic [LOG_W-1:0]  w_cx;
  logic [LOG_H-1:0]  w_cy;
  logic [3:0]        w_ncount;
  logic              w_old, w_new, w_wbit, w_last, w_accept, w_busy;
  logic [LOG_N-1:0]  w_tog_idx;
  logic              w_tog_old;
  logic [PW-1:0]     w_acc_next;

  // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
  // cmd_ready is high only in IDLE, and the requester holds its fields until then.
  assign w_accept     = cmd_valid & cmd_ready;
  assign w_front_bank = r_front ? r_bank_b : r_bank_a;
  assign rd_cell      = w_front_bank[{rd_y, rd_x}];
  assign w_cx         = r_idx[LOG_W-1:0];
  assign w_cy         = r_idx[LOG_N-1:LOG_W];
  assign w_old        = w_front_bank[r_idx];
  assign w_new        = w_old ? SURVIVE_MASK[w_ncount] : BIRTH_MASK[w_ncount];
  assign w_wbit       = (r_state == S_STEP) ? w_new : (r_fill_rand & r_lfsr[0]);
  assign w_last       = (r_idx == LOG_N'(N - 1));
  assign w_tog_idx    = {cmd_y, cmd_x};
  assign w_tog_old    = w_front_bank[w_tog_idx];
  assign w_acc_next   = r_acc + {{(PW-1){1'b0}}, w_wbit};

  // Neighbour count of the cell under the index counter, from the front bank.
  always_comb begin
    int               nx;
    int               ny;
    logic [LOG_W-1:0] wx;
    logic [LOG_H-1:0] wy;
    logic             inb;
    w_ncount = 4'd0;
    nx = 0;
    ny = 0;
    wx = '0;
    wy = '0;
    inb = 1'b0;
    for (int dy = -1; dy <= 1; dy++) begin
      for (int dx = -1; dx <= 1; dx++) begin
        if (!(dx == 0 && dy == 0)) begin
          nx  = int'(w_cx) + dx;
          ny  = int'(w_cy) + dy;
          wx  = nx[LOG_W-1:0];
          wy  = ny[LOG_H-1:0];
          inb = (nx >= 0) && (nx < W) && (ny >= 0) && (ny < H);
          if (WRAP || inb)
            w_ncount = w_ncount + {3'b000, w_front_bank[{wy, wx}]};
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (cmd_op == OP_STEP)        w_next = S_STEP;
          else if (cmd_op != OP_TOGGLE) w_next = S_FILL;
        end
      end
      S_STEP, S_FILL: if (w_last) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (r_state == S_IDLE);
    w_busy    = (r_state == S_STEP) || (r_state == S_FILL);
    dbg_state = r_state;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bank_a    <= '0;
      r_bank_b    <= '0;
      r_front     <= 1'b0;
      r_idx       <= '0;
      r_lfsr      <= SEED;
      r_fill_rand <= 1'b0;
      r_acc       <= '0;
      r_diff      <= 1'b0;
      r_done      <= 1'b0;
      r_gen       <= 16'd0;
      r_pop       <= '0;
      r_stable    <= 1'b0;
    end else begin
      r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
      r_done <= 1'b0;
      if (w_busy) begin
        if (r_front) r_bank_a[r_idx] <= w_wbit;
        else         r_bank_b[r_idx] <= w_wbit;
        r_idx  <= r_idx + 1'b1;
        r_acc  <= w_acc_next;
        r_diff <= r_diff | (w_wbit != w_old);
        if (w_last) begin
          r_front <= ~r_front;
          r_pop   <= w_acc_next;
          r_done  <= 1'b1;
          if (r_state == S_STEP) begin
            r_gen    <= r_gen + 16'd1;
            r_stable <= ~(r_diff | (w_wbit != w_old));
          end else begin
            r_gen    <= 16'd0;
            r_stable <= 1'b0;
          end
        end
      end else if (w_accept) begin
        r_idx       <= '0;
        r_acc       <= '0;
        r_diff      <= 1'b0;
        r_fill_rand <= (cmd_op == OP_RAND);
        if (cmd_op == OP_TOGGLE) begin
          if (r_front) r_bank_b[w_tog_idx] <= ~w_tog_old;
          else         r_bank_a[w_tog_idx] <= ~w_tog_old;
          r_pop    <= w_tog_old ? (r_pop - {{(PW-1){1'b0}}, 1'b1})
                                : (r_pop + {{(PW-1){1'b0}}, 1'b1});
          r_stable <= 1'b0;
          r_done   <= 1'b1;
        end
      end
    end
  end

  assign busy       = w_busy;
  assign done       = r_done;
  assign generation = r_gen;
  assign population = r_pop;
  assign stable     = r_stable;
endmodule

// File: tb/tb_life_engine.sv
// Directed bench for life_engine on 8x8 boards: one torus instance and one
// dead-edge instance driven in lockstep from the same command stream.
module tb_life_engine;
  localparam logic [15:0] SEED = 16'h0001;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic [1:0] cmd_op;
  logic [2:0] cmd_x, cmd_y, rd_x, rd_y;

  logic       t_ready, t_rd, t_busy, t_done, t_stable;
  logic [15:0] t_gen;
  logic [6:0] t_pop;
  logic [1:0] t_state;
  logic       d_ready, d_rd, d_busy, d_done, d_stable;
  logic [15:0] d_gen;
  logic [6:0] d_pop;
  logic [1:0] d_state;

  int vec = 0;
  int mis = 0;
  int cyc;

  life_engine #(.LOG_W(3), .LOG_H(3), .WRAP(1'b1), .SEED(SEED)) dut_t (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(t_ready),
    .cmd_op(cmd_op), .cmd_x(cmd_x), .cmd_y(cmd_y), .rd_x(rd_x), .rd_y(rd_y),
    .rd_cell(t_rd), .busy(t_busy), .done(t_done), .generation(t_gen),
    .population(t_pop), .stable(t_stable), .dbg_state(t_state));

  life_engine #(.LOG_W(3), .LOG_H(3), .WRAP(1'b0), .SEED(SEED)) dut_d (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(d_ready),
    .cmd_op(cmd_op), .cmd_x(cmd_x), .cmd_y(cmd_y), .rd_x(rd_x), .rd_y(rd_y),
    .rd_cell(d_rd), .busy(d_busy), .done(d_done), .generation(d_gen),
    .population(d_pop), .stable(d_stable), .dbg_state(d_state));

  // clock / reset-tracked cycle counter for the LFSR reference
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec++;
    assert (obs === exp) else begin
      mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int ci(input int x, input int y);
    return y * 8 + x;
  endfunction

  function automatic logic [63:0] glider(input int k);
    logic [63:0] b;
    int gx[5];
    int gy[5];
    gx = '{1, 2, 0, 1, 2};
    gy = '{0, 1, 2, 2, 2};
    b = '0;
    for (int i = 0; i < 5; i++) b[ci((gx[i] + k) % 8, (gy[i] + k) % 8)] = 1'b1;
    return b;
  endfunction

  function automatic logic [15:0] lfsr_nx(input logic [15:0] q);
    return {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
  endfunction

  // driver tasks
  task automatic issue(input logic [1:0] op, input int x, input int y, output int acc_cyc);
    int guard;
    guard = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_x     = x[2:0];
    cmd_y     = y[2:0];
    while (!t_ready && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    check("issue_ready", t_ready, 1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    acc_cyc   = cyc;
  endtask

  task automatic wait_done(output int busy_cycles);
    busy_cycles = 0;
    @(negedge clk);
    while (t_busy && busy_cycles < 1000) begin
      busy_cycles++;
      @(negedge clk);
    end
    check("done_pulse", t_done, 1);
    @(negedge clk);
    check("done_drop", t_done, 0);
  endtask

  task automatic run_cmd(input logic [1:0] op, output int busy_cycles);
    int c;
    issue(op, 0, 0, c);
    wait_done(busy_cycles);
  endtask

  task automatic toggle(input int x, input int y, input int exp_pop);
    int c;
    issue(2'd3, x, y, c);
    check("toggle_done", t_done, 1);
    check("toggle_busy", t_busy, 0);
    check("toggle_pop", t_pop, exp_pop);
  endtask

  task automatic read_board(output logic [63:0] bt, output logic [63:0] bd);
    for (int i = 0; i < 64; i++) begin
      rd_x = i[2:0];
      rd_y = i[5:3];
      #1;
      bt[i] = t_rd;
      bd[i] = d_rd;
    end
  endtask

  initial begin
    logic [63:0] bt, bd, exp_b;
    logic [15:0] q;
    int bc, c1, c2, cnt, ones, done_seen;

    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = 2'd0;
    cmd_x = 3'd0;
    cmd_y = 3'd0;
    rd_x = 3'd0;
    rd_y = 3'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // reset state
    #1;
    check("rst_ready", t_ready, 1);
    check("rst_busy", t_busy, 0);
    check("rst_done", t_done, 0);
    check("rst_pop", t_pop, 0);
    check("rst_gen", t_gen, 0);
    check("rst_stable", t_stable, 0);
    read_board(bt, bd);
    check("rst_board_t", bt, 64'd0);
    check("rst_board_d", bd, 64'd0);

    // vertical blinker, two steps
    toggle(3, 2, 1);
    toggle(3, 3, 2);
    toggle(3, 4, 3);
    exp_b = '0;
    exp_b[ci(3, 2)] = 1'b1;
    exp_b[ci(3, 3)] = 1'b1;
    exp_b[ci(3, 4)] = 1'b1;
    read_board(bt, bd);
    check("blinker_vert_init", bt, exp_b);
    run_cmd(2'd0, bc);
    check("blinker_busy_cycles", bc, 64);
    exp_b = '0;
    exp_b[ci(2, 3)] = 1'b1;
    exp_b[ci(3, 3)] = 1'b1;
    exp_b[ci(4, 3)] = 1'b1;
    read_board(bt, bd);
    check("blinker_horiz", bt, exp_b);
    check("blinker_pop", t_pop, 3);
    check("blinker_gen", t_gen, 1);
    check("blinker_stable", t_stable, 0);
    run_cmd(2'd0, bc);
    exp_b = '0;
    exp_b[ci(3, 2)] = 1'b1;
    exp_b[ci(3, 3)] = 1'b1;
    exp_b[ci(3, 4)] = 1'b1;
    read_board(bt, bd);
    check("blinker_vert_again", bt, exp_b);
    check("blinker_gen2", t_gen, 2);

    // clear, then 2x2 still life
    run_cmd(2'd2, bc);
    check("clear_busy_cycles", bc, 64);
    check("clear_pop", t_pop, 0);
    check("clear_gen", t_gen, 0);
    read_board(bt, bd);
    check("clear_board", bt, 64'd0);
    toggle(1, 1, 1);
    toggle(2, 1, 2);
    toggle(1, 2, 3);
    toggle(2, 2, 4);
    exp_b = '0;
    exp_b[ci(1, 1)] = 1'b1;
    exp_b[ci(2, 1)] = 1'b1;
    exp_b[ci(1, 2)] = 1'b1;
    exp_b[ci(2, 2)] = 1'b1;
    run_cmd(2'd0, bc);
    check("block_pop", t_pop, 4);
    check("block_stable", t_stable, 1);
    read_board(bt, bd);
    check("block_board", bt, exp_b);

    // glider: returns home on the torus, freezes into a corner block on the dead-edge board
    run_cmd(2'd2, bc);
    toggle(1, 0, 1);
    toggle(2, 1, 2);
    toggle(0, 2, 3);
    toggle(1, 2, 4);
    toggle(2, 2, 5);
    read_board(bt, bd);
    check("glider_init", bt, glider(0));
    for (int k = 1; k <= 32; k++) begin
      run_cmd(2'd0, bc);
      check("glider_pop_torus", t_pop, 5);
    end
    read_board(bt, bd);
    check("glider_home_torus", bt, glider(0));
    check("glider_gen", t_gen, 32);
    exp_b = '0;
    exp_b[ci(6, 6)] = 1'b1;
    exp_b[ci(7, 6)] = 1'b1;
    exp_b[ci(6, 7)] = 1'b1;
    exp_b[ci(7, 7)] = 1'b1;
    check("glider_corner_dead", bd, exp_b);
    check("glider_pop_dead", d_pop, 4);
    check("glider_stable_dead", d_stable, 1);

    // randomize against a reference LFSR
    issue(2'd1, 0, 0, c1);
    wait_done(bc);
    q = SEED;
    for (int i = 0; i < c1; i++) q = lfsr_nx(q);
    exp_b = '0;
    ones = 0;
    for (int i = 0; i < 64; i++) begin
      exp_b[i] = q[0];
      ones += int'(q[0]);
      q = lfsr_nx(q);
    end
    read_board(bt, bd);
    check("rand_board_t", bt, exp_b);
    check("rand_board_d", bd, exp_b);
    check("rand_pop", t_pop, ones);
    check("rand_gen", t_gen, 0);
    check("rand_stable", t_stable, 0);

    // cmd_valid held through a STEP: second acceptance only on the done cycle
    issue(2'd0, 0, 0, c1);
    cmd_valid = 1'b1;
    cmd_op = 2'd0;
    cnt = 0;
    @(negedge clk);
    while (!t_ready && cnt < 1000) begin
      cnt++;
      @(negedge clk);
    end
    check("held_wait_cycles", cnt, 64);
    check("held_done_cycle", t_done, 1);
    @(posedge clk);
    #1;
    c2 = cyc;
    cmd_valid = 1'b0;
    check("held_accept_gap", c2 - c1, 65);
    check("held_busy_after", t_busy, 1);
    wait_done(bc);
    check("held_gen", t_gen, 2);

    // reset during cell 20 of a STEP
    issue(2'd0, 0, 0, c1);
    repeat (20) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("abort_ready", t_ready, 1);
    check("abort_busy", t_busy, 0);
    check("abort_done", t_done, 0);
    check("abort_gen", t_gen, 0);
    check("abort_pop", t_pop, 0);
    check("abort_stable", t_stable, 0);
    read_board(bt, bd);
    check("abort_board", bt, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      if (t_done) done_seen++;
    end
    check("abort_no_done", done_seen, 0);

    run_cmd(2'd2, bc);
    check("final_clear_pop", t_pop, 0);
    check("final_clear_gen", t_gen, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end
endmodule
